// File: rtl/pmp_pkg.sv
// pmp_pkg: shared types and constants for the PMP request arbiter
package pmp_pkg;
   localparam int PMP_MSB = 55;
   localparam logic [1:0] ACC_EXEC = 2'b00;
   typedef enum logic {TAG_I, TAG_D} pmp_tag_e;
   typedef enum logic [1:0] {RUN, DRAIN, ACK, HOLD} arb_state_e;
   typedef struct packed {
      logic [PMP_MSB:0] address;
      logic [1:0]       acc;
      logic [1:0]       prv;
      logic             mprv;
      logic [1:0]       mpp;
   } pmp_chk_req_t;
endpackage

// File: rtl/pmp_tag_pipe.sv
// pmp_tag_pipe: requester tag delay line, response routing and in-flight count
module pmp_tag_pipe
   import pmp_pkg::*;
#(
   parameter int lat = 1,
   parameter int cw  = $clog2(lat + 2)
) (
   input  logic          clk300p,
   input  logic          rstn,
   input  logic          issue,
   input  pmp_tag_e      tag,
   input  logic          chk_ok,
   output logic          i_rsp_valid,
   output logic          i_rsp_ok,
   output logic          d_rsp_valid,
   output logic          d_rsp_ok,
   output logic [cw-1:0] inflight
);
   logic tail_v, tail_d;
   if (lat == 0) begin : g_direct
      assign tail_v = issue;
      assign tail_d = tag == TAG_D;
   end else begin : g_shift
      logic [lat-1:0] v, d;
      always_ff @(posedge clk300p)
         if (!rstn) begin
            v <= '0;
            d <= '0;
         end else begin
            v <= lat'({v, issue});
            d <= lat'({d, tag == TAG_D});
         end
      assign tail_v = v[lat-1];
      assign tail_d = d[lat-1];
   end
   // a check leaves the count once its result is back from the checker
   always_ff @(posedge clk300p)
      if (!rstn) begin
         i_rsp_valid <= 1'b0;
         i_rsp_ok    <= 1'b0;
         d_rsp_valid <= 1'b0;
         d_rsp_ok    <= 1'b0;
         inflight    <= '0;
      end else begin
         i_rsp_valid <= tail_v && !tail_d;
         i_rsp_ok    <= tail_v && !tail_d && chk_ok;
         d_rsp_valid <= tail_v && tail_d;
         d_rsp_ok    <= tail_v && tail_d && chk_ok;
         inflight    <= inflight + cw'(issue) - cw'(tail_v);
      end
endmodule

// File: rtl/pmp_req_arbiter.sv
// pmp_req_arbiter: shares one PMP checker between fetch and data requesters
module pmp_req_arbiter
   import pmp_pkg::*;
#(
   parameter int pmp_msb = PMP_MSB,
   parameter int chk_lat = 1,
   parameter bit fair_rr = 1'b1
) (
   input  logic             clk300p,
   input  logic             rstn,
   input  logic             i_req,
   input  logic [pmp_msb:0] i_addr,
   input  logic [1:0]       i_prv,
   output logic             i_gnt,
   output logic             i_rsp_valid,
   output logic             i_rsp_ok,
   input  logic             d_req,
   input  logic [pmp_msb:0] d_addr,
   input  logic [1:0]       d_acc,
   input  logic [1:0]       d_prv,
   output logic             d_gnt,
   output logic             d_rsp_valid,
   output logic             d_rsp_ok,
   input  logic             mprv,
   input  logic [1:0]       mpp,
   input  logic             cfg_req,
   output logic             cfg_ack,
   output logic             chk_valid,
   output logic [pmp_msb:0] chk_address,
   output logic [1:0]       chk_acc,
   output logic [1:0]       chk_prv,
   output logic             chk_mprv,
   output logic [1:0]       chk_mpp,
   input  logic             chk_ok
);
   localparam int aw = pmp_msb + 1;
   localparam int pw = PMP_MSB + 1;
   localparam int cw = $clog2(chk_lat + 2);
   arb_state_e   state, nxt;
   pmp_tag_e     ptr;
   pmp_chk_req_t ireq, dreq, req;
   logic [cw-1:0] inflight;
   logic run, d_first;
   assign run     = rstn && state == RUN && !cfg_req;
   assign d_first = !fair_rr || ptr == TAG_D;
   assign d_gnt   = run && d_req && (!i_req || d_first);
   assign i_gnt   = run && i_req && !(d_req && d_first);
   assign cfg_ack = rstn && state == ACK;
   assign chk_valid = i_gnt || d_gnt;
   assign ireq = '{address: pw'(i_addr), acc: ACC_EXEC, prv: i_prv, mprv: 1'b0, mpp: 2'b00};
   assign dreq = '{address: pw'(d_addr), acc: d_acc, prv: d_prv, mprv: mprv, mpp: mpp};
   assign req  = d_gnt ? dreq : i_gnt ? ireq : '0;
   assign chk_address = aw'(req.address);
   assign chk_acc     = req.acc;
   assign chk_prv     = req.prv;
   assign chk_mprv    = req.mprv;
   assign chk_mpp     = req.mpp;
   always_comb
      nxt = (state == RUN)   ? (cfg_req ? DRAIN : RUN) :
            (state == DRAIN) ? (inflight == '0 ? ACK : DRAIN) :
            (state == ACK)   ? HOLD :
                               (cfg_req ? HOLD : RUN);
   always_ff @(posedge clk300p)
      if (!rstn) begin
         state <= RUN;
         ptr   <= TAG_I;
      end else begin
         state <= nxt;
         if (chk_valid) ptr <= d_gnt ? TAG_I : TAG_D;
      end
   pmp_tag_pipe #(.lat(chk_lat), .cw(cw)) u_pipe (
      .clk300p     (clk300p),
      .rstn        (rstn),
      .issue       (chk_valid),
      .tag         (d_gnt ? TAG_D : TAG_I),
      .chk_ok      (chk_ok),
      .i_rsp_valid (i_rsp_valid),
      .i_rsp_ok    (i_rsp_ok),
      .d_rsp_valid (d_rsp_valid),
      .d_rsp_ok    (d_rsp_ok),
      .inflight    (inflight)
   );
endmodule

// File: tb/tb_pmp_req_arbiter.sv
// tb_pmp_req_arbiter: scoreboard bench with a transaction-level arbiter model
module tb_pmp_req_arbiter;
   import pmp_pkg::*;
   localparam int LAT = 1;
   typedef struct {
      int   due;
      logic d;
      logic ok;
   } exp_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rstn, i_req, d_req, mprv, cfg_req, fp_i_req, fp_d_req;
   logic [PMP_MSB:0] i_addr, d_addr;
   logic [1:0] i_prv, d_acc, d_prv, mpp;
   logic i_gnt, i_rsp_valid, i_rsp_ok, d_gnt, d_rsp_valid, d_rsp_ok, cfg_ack, chk_valid, chk_mprv;
   logic [PMP_MSB:0] chk_address;
   logic [1:0] chk_acc, chk_prv, chk_mpp;
   logic fp_i_gnt, fp_i_rsp_valid, fp_i_rsp_ok, fp_d_gnt, fp_d_rsp_valid, fp_d_rsp_ok, fp_cfg_ack, fp_chk_valid, fp_chk_mprv;
   logic [PMP_MSB:0] fp_chk_address;
   logic [1:0] fp_chk_acc, fp_chk_prv, fp_chk_mpp;
   logic ok_q = 1'b0;
   int cyc = 0;
   int tests = 0, fails = 0;
   exp_t q[$];
   exp_t me;
   logic prefer_d, frozen, acked, i_take, d_take;
   int fc, ac, last_due;

   pmp_req_arbiter #(.pmp_msb(PMP_MSB), .chk_lat(LAT), .fair_rr(1'b1)) dut (
      .clk300p(clk), .rstn(rstn),
      .i_req(i_req), .i_addr(i_addr), .i_prv(i_prv), .i_gnt(i_gnt),
      .i_rsp_valid(i_rsp_valid), .i_rsp_ok(i_rsp_ok),
      .d_req(d_req), .d_addr(d_addr), .d_acc(d_acc), .d_prv(d_prv), .d_gnt(d_gnt),
      .d_rsp_valid(d_rsp_valid), .d_rsp_ok(d_rsp_ok),
      .mprv(mprv), .mpp(mpp), .cfg_req(cfg_req), .cfg_ack(cfg_ack),
      .chk_valid(chk_valid), .chk_address(chk_address), .chk_acc(chk_acc),
      .chk_prv(chk_prv), .chk_mprv(chk_mprv), .chk_mpp(chk_mpp), .chk_ok(ok_q)
   );

   pmp_req_arbiter #(.pmp_msb(PMP_MSB), .chk_lat(LAT), .fair_rr(1'b0)) dut_fp (
      .clk300p(clk), .rstn(rstn),
      .i_req(fp_i_req), .i_addr(i_addr), .i_prv(i_prv), .i_gnt(fp_i_gnt),
      .i_rsp_valid(fp_i_rsp_valid), .i_rsp_ok(fp_i_rsp_ok),
      .d_req(fp_d_req), .d_addr(d_addr), .d_acc(d_acc), .d_prv(d_prv), .d_gnt(fp_d_gnt),
      .d_rsp_valid(fp_d_rsp_valid), .d_rsp_ok(fp_d_rsp_ok),
      .mprv(mprv), .mpp(mpp), .cfg_req(1'b0), .cfg_ack(fp_cfg_ack),
      .chk_valid(fp_chk_valid), .chk_address(fp_chk_address), .chk_acc(fp_chk_acc),
      .chk_prv(fp_chk_prv), .chk_mprv(fp_chk_mprv), .chk_mpp(fp_chk_mpp), .chk_ok(1'b0)
   );

   always @(posedge clk) cyc <= cyc + 1;
   // stand-in checker: permits an access when address bit 3 is set
   always @(posedge clk) ok_q <= chk_valid & chk_address[3];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic newi();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      i_addr = r[PMP_MSB:0];
      i_prv  = 2'($urandom());
   endtask

   task automatic newd();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      d_addr = r[PMP_MSB:0];
      d_acc  = 2'($urandom());
      d_prv  = 2'($urandom());
      mprv   = 1'($urandom());
      mpp    = 2'($urandom());
   endtask

   task automatic refresh();
      if (i_take) newi();
      if (d_take) newd();
   endtask

   task automatic gen();
      if (!i_req || i_take) begin
         i_req = $urandom_range(0, 3) != 0;
         newi();
      end
      if (!d_req || d_take) begin
         d_req = $urandom_range(0, 3) != 0;
         newd();
      end
   endtask

   // one clock: predict grants/ack from the model, compare, record expected responses
   task automatic step();
      logic ei, ed, ea, can;
      @(negedge clk);
      ei = 1'b0;
      ed = 1'b0;
      ea = 1'b0;
      if (!rstn) begin
         prefer_d = 1'b0;
         frozen   = 1'b0;
         acked    = 1'b0;
         last_due = cyc;
         while (q.size() > 0 && q[q.size()-1].due > cyc) void'(q.pop_back());
      end else begin
         can = !frozen && !cfg_req;
         if (!frozen && cfg_req) begin
            frozen = 1'b1;
            acked  = 1'b0;
            fc     = cyc;
         end
         ed = can && d_req && (!i_req || prefer_d);
         ei = can && i_req && !ed;
         if (frozen && !acked && cyc >= fc + 2 && last_due < cyc) begin
            ea    = 1'b1;
            acked = 1'b1;
            ac    = cyc;
         end else if (frozen && acked && cyc > ac && !cfg_req) frozen = 1'b0;
      end
      chk("i_gnt", i_gnt, ei);
      chk("d_gnt", d_gnt, ed);
      chk("chk_valid", chk_valid, ei | ed);
      chk("cfg_ack", cfg_ack, ea);
      chk("fp_d_gnt", fp_d_gnt, rstn && fp_d_req);
      chk("fp_i_gnt", fp_i_gnt, rstn && fp_i_req && !fp_d_req);
      if (ei | ed) begin
         chk("chk_address", chk_address, ed ? d_addr : i_addr);
         chk("chk_acc", chk_acc, ed ? d_acc : ACC_EXEC);
         chk("chk_prv", chk_prv, ed ? d_prv : i_prv);
         chk("chk_mprv", chk_mprv, ed ? mprv : 1'b0);
         chk("chk_mpp", chk_mpp, ed ? mpp : 2'b00);
         q.push_back('{cyc + LAT + 1, ed, ed ? d_addr[3] : i_addr[3]});
         last_due = cyc + LAT + 1;
         prefer_d = ei;
      end
      i_take = ei;
      d_take = ed;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due <= cyc) begin
         me = q.pop_front();
         chk("rsp_valid", {d_rsp_valid, i_rsp_valid}, me.d ? 2'b10 : 2'b01);
         chk("rsp_ok", me.d ? d_rsp_ok : i_rsp_ok, me.ok);
      end else chk("rsp_idle", {d_rsp_valid, i_rsp_valid}, 2'b00);
   end

   initial begin
      rstn = 1'b0;
      i_req = 1'b1;
      d_req = 1'b1;
      cfg_req = 1'b0;
      fp_i_req = 1'b0;
      fp_d_req = 1'b0;
      i_take = 1'b0;
      d_take = 1'b0;
      prefer_d = 1'b0;
      frozen = 1'b0;
      acked = 1'b0;
      fc = 0;
      ac = 0;
      last_due = 0;
      newi();
      newd();
      repeat (3) begin
         step();
         chk("rst_outs", {i_gnt, d_gnt, chk_valid, cfg_ack, i_rsp_valid, i_rsp_ok, d_rsp_valid, d_rsp_ok}, 8'h00);
      end
      rstn = 1'b1;
      repeat (6) begin
         refresh();
         step();
      end
      fp_i_req = 1'b1;
      fp_d_req = 1'b1;
      i_req = 1'b0;
      d_req = 1'b0;
      repeat (4) step();
      fp_i_req = 1'b0;
      fp_d_req = 1'b0;
      newd();
      d_acc = 2'b01;
      mprv = 1'b1;
      mpp = 2'b11;
      d_req = 1'b1;
      step();
      newi();
      i_req = 1'b1;
      d_req = 1'b0;
      step();
      i_req = 1'b0;
      repeat (2) step();
      i_req = 1'b1;
      d_req = 1'b1;
      repeat (2) begin
         refresh();
         step();
      end
      refresh();
      d_req = 1'b0;
      cfg_req = 1'b1;
      repeat (6) step();
      cfg_req = 1'b0;
      repeat (3) begin
         refresh();
         step();
      end
      i_req = 1'b1;
      d_req = 1'b1;
      repeat (2) begin
         refresh();
         step();
      end
      rstn = 1'b0;
      i_req = 1'b0;
      d_req = 1'b0;
      step();
      rstn = 1'b1;
      repeat (4) step();
      chk("inflight_after_rst", 64'(dut.u_pipe.inflight), 0);
      repeat (1500) begin
         gen();
         fp_i_req = 1'($urandom());
         fp_d_req = 1'($urandom());
         if (!cfg_req) cfg_req = $urandom_range(0, 39) == 0;
         else if (acked ? $urandom_range(0, 2) == 0 : $urandom_range(0, 15) == 0) cfg_req = 1'b0;
         rstn = $urandom_range(0, 299) != 0;
         step();
      end
      rstn = 1'b1;
      cfg_req = 1'b0;
      i_req = 1'b0;
      d_req = 1'b0;
      fp_i_req = 1'b0;
      fp_d_req = 1'b0;
      repeat (8) step();
      chk("queue_empty", 64'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/pmp_req_arbiter.md
Name: pmp_req_arbiter

Overview:
- Shares one PMP checker instance between two requesters: instruction fetch (port I) and data access (port D).
- Round-robin arbitration with a req/gnt handshake; at most one issue per cycle.
- Pipelined: results return in issue order after a fixed checker latency and are routed back by requester tag.
- Sequences PMP configuration updates: on a config-change request it stops issuing, drains in-flight checks, then acknowledges so the CSR block can write pmpcfg/pmpaddr safely.

Parameters:
- pmp_msb, 55, MSB of the physical address.
- chk_lat, 1, cycles from chk_valid to a valid chk_ok; legal range 0..4.
- fair_rr, 1, 1 = round-robin; 0 = fixed priority with D over I.

Ports:
- clk300p  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- i_req  in  1  fetch check request
- i_addr  in  pmp_msb+1  fetch address
- i_prv  in  2  fetch privilege
- i_gnt  out  1  fetch request accepted this cycle
- i_rsp_valid  out  1  fetch result strobe
- i_rsp_ok  out  1  fetch access permitted
- d_req  in  1  data check request
- d_addr  in  pmp_msb+1  data address
- d_acc  in  2  data access type
- d_prv  in  2  data privilege
- d_gnt  out  1  data request accepted this cycle
- d_rsp_valid  out  1  data result strobe
- d_rsp_ok  out  1  data access permitted
- mprv  in  1  mstatus.MPRV, passed through on D issues
- mpp  in  2  mstatus.MPP, passed through on D issues
- cfg_req  in  1  level; CSR block wants to update PMP config
- cfg_ack  out  1  one-cycle pulse; pipeline is empty and issue is frozen
- chk_valid  out  1  to checker
- chk_address  out  pmp_msb+1  to checker
- chk_acc  out  2  to checker
- chk_prv  out  2  to checker
- chk_mprv  out  1  to checker
- chk_mpp  out  2  to checker
- chk_ok  in  1  from checker, valid chk_lat cycles after chk_valid

Behaviour:
- Reset (rstn=0 at a clk300p edge) clears all outputs to 0, clears the tag pipeline, sets the RR pointer to I and the FSM to RUN. Results of checks in flight at reset are discarded; no rsp_valid is emitted for them.
- FSM states: RUN, DRAIN, ACK, HOLD.
  - RUN: arbitrate; go to DRAIN when cfg_req=1. cfg_req has priority over requests presented in the same cycle, so no grant is given in that cycle.
  - DRAIN: no grants; go to ACK when the in-flight count is 0.
  - ACK: cfg_ack=1 for one cycle, then go to HOLD.
  - HOLD: no grants until cfg_req=0, then go to RUN.
  - If cfg_req deasserts during DRAIN, the FSM still completes DRAIN→ACK→HOLD→RUN.
- Grant rule: gnt is combinational on req, FSM state and RR pointer. Exactly zero or one of i_gnt/d_gnt is high.
  - Both requesting with fair_rr=1: the grant goes to the side the pointer names, and the pointer flips to the other side after each grant.
  - A single requester is granted every cycle.
- Issue: chk_valid = i_gnt|d_gnt. chk_* fields are muxed from the granted side.
  - I issues drive chk_acc=2'b00 (execute), chk_mprv=0, chk_mpp=0.
  - D issues pass d_acc, mprv and mpp through.
  - chk_* outputs are combinational in the issue cycle. The checker samples them.
- Tag pipeline: a shift register of depth chk_lat carries {valid, tag}, tag 0=I, 1=D.
  - At the tail, the entry's valid and tag select which rsp_valid pulses; rsp_ok = chk_ok registered through the response flop.
  - Response latency is chk_lat+1 cycles from gnt.
  - chk_lat=0: tag is used directly and the response comes 1 cycle after gnt.
- In-flight counter: width clog2(chk_lat+2); +1 on issue, -1 on response, both in the same cycle leave it unchanged. It never exceeds chk_lat+1.
- Requesters hold req and fields stable until gnt. Fields are don't-care when req=0.
- Responses have no backpressure; each requester must sink one result per cycle.

Decomposition:
- pmp_pkg additions:
  - typedef pmp_tag_e {TAG_I, TAG_D}
  - typedef arb_state_e {RUN, DRAIN, ACK, HOLD}
  - constant ACC_EXEC=2'b00
  - struct pmp_chk_req_t {address, acc, prv, mprv, mpp}
- One sub-module: pmp_tag_pipe (parameterised shift register plus in-flight counter). Arbitration and FSM stay in the top level.

Test Plan:
- Reset with i_req=d_req=1 held, rstn low for 3 cycles -> all outputs 0; first grant goes to I on the cycle rstn rises.
- i_req=d_req=1 for 6 cycles, chk_lat=1 -> grants alternate I,D,I,D,I,D; i_rsp_valid/d_rsp_valid alternate starting 2 cycles after the first gnt; rsp_ok equals chk_ok driven 1 cycle earlier (model returns ok = addr[3]).
- D issue with d_acc=2'b01, mprv=1, mpp=2'b11 -> chk_acc=01, chk_mprv=1, chk_mpp=11 in the grant cycle; an I issue in the next cycle -> chk_acc=00, chk_mprv=0.
- cfg_req rises while 2 checks are in flight and i_req=1 -> no gnt from that cycle on; cfg_ack pulses exactly once, the cycle after the last rsp_valid; grants resume the cycle after cfg_req falls.
- rstn low for 1 cycle with 2 checks in flight -> no rsp_valid afterwards for those checks; in-flight count 0.
- fair_rr=0 with both requesting for 4 cycles -> d_gnt=1 all 4 cycles, i_gnt=0.
